lfsr_gen: RTL and testbench
===========================

// Module: lfsr_gen
// PURPOSE
//  Parametrised successor to the fixed 5-bit LFSR: WIDTH-bit shift register with runtime taps and seed.
//  Adds run-time Fibonacci/Galois mode, STEP shifts per advance, all-zero lock-up detect/recovery and period measurement.
//  Used as a PRBS/scrambler source in datapath test logic; out / out_state keep the legacy meaning.
// PARAMETERS
//  WIDTH        5   register width (>=2)
//  STEP         1   shifts applied per advance cycle (1..WIDTH)
//  CNT_W        16  width of period counter / period_len
//  AUTO_RECOVER 1   1: advance from all-zero state reloads seed (or 1); 0: stay locked
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       synchronous, active-high reset
//  reinit         in   1       load initial_state this cycle
//  advance        in   1       perform STEP shifts this cycle
//  mode           in   1       0 = Fibonacci, 1 = Galois; sampled each advance
//  initial_state  in   WIDTH   seed value
//  taps           in   WIDTH   tap mask; taps[0] ignored in Galois mode
//  out            out  1       state[0], registered
//  out_state      out  WIDTH   current state
//  lockup         out  1       registered: state == 0
//  period_hit     out  1       one-cycle pulse: state returned to loaded seed
//  period_len     out  CNT_W   advances between load and latest period_hit
// BEHAVIOUR
//  - Priority: rst > reinit > advance > hold. All updates registered, latency 1 cycle.
//  - rst or reinit: state <= initial_state; cnt <= 0; seed_q <= initial_state; period_hit <= 0.
//    rst additionally clears period_len to 0. lockup <= (initial_state == 0).
//  - Fibonacci shift: fb = ^(taps & s); s_next = {s[WIDTH-2:0], fb}.
//  - Galois shift: m = s[WIDTH-1]; s_next[0] = m; s_next[i] = s[i-1] ^ (taps[i] & m), i>=1.
//  - advance: STEP single shifts chained combinationally, all in the current mode.
//  - advance with state == 0 and AUTO_RECOVER=1: no shift; state <= (initial_state != 0) ? initial_state : 1;
//    cnt <= 0; seed_q <= loaded value. With AUTO_RECOVER=0: state held at 0; cnt still increments.
//  - Period: each advance increments cnt (saturates at 2^CNT_W-1).
//    When post-advance state == seed_q: period_hit <= 1; period_len <= cnt+1 (saturated); cnt <= 0.
//  - period_hit is low in every cycle that did not satisfy the condition above; never fires on load cycle.
//  - Mode or taps change mid-sequence: takes effect on next advance; counter not reset.
//  - out == out_state[0], lockup == (out_state == 0) at every cycle after the first clock with rst.
// STRUCTURE
//  - lfsr_pkg: typedef enum logic {LFSR_FIB=1'b0, LFSR_GAL=1'b1} lfsr_mode_e;
//    function lfsr_shift1(state, taps, mode) shared with the scrambler blocks.
//  - Sub-module lfsr_next: combinational STEP-fold unroll of lfsr_shift1; lfsr_gen holds registers/counters.
// TESTING (WIDTH=5, STEP=1 unless stated)
//  1. rst with initial_state=5'b00001 -> out_state=00001, out=1, lockup=0, period_hit=0, period_len=0.
//  2. Fib, taps=10100, seed 00001, 3 advances -> 00010, 00100, 01001; out 0,0,1.
//  3. Same setup, 31 advances -> period_hit pulses once in the cycle after the 31st, period_len=31, state=00001.
//  4. Galois, taps=00101, seed 10000, 1 advance -> 00101; STEP=2 build: one advance from seed -> 01010.
//  5. reinit with initial_state=0 -> lockup=1; advance -> state 00001, lockup=0; AUTO_RECOVER=0 build stays 00000.
//  6. reinit and advance same cycle mid-run (seed 00110) -> state 00110, cnt 0; rst mid-run -> period_len=0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR types and the single-shift helper used by the generator and the scrambler blocks.
package lfsr_pkg;

    typedef enum logic {LFSR_FIB = 1'b0, LFSR_GAL = 1'b1} lfsr_mode_e;

    localparam int LFSR_MAX_W = 64;
    typedef logic [LFSR_MAX_W-1:0] lfsr_word_t;

    // One Fibonacci or Galois shift of the low 'width' bits; bits above width come back zero.
    function automatic lfsr_word_t lfsr_shift1(input lfsr_word_t state,
                                               input lfsr_word_t taps,
                                               input lfsr_mode_e mode,
                                               input int         width);
        lfsr_word_t mask;
        lfsr_word_t res;
        logic       msb;
        logic       fb;
        mask = '0;
        for (int i = 0; i < LFSR_MAX_W; i++) begin
            mask[i] = (i < width);
        end
        msb = |(state & mask & ~(mask >> 1));
        fb  = ^(taps & state & mask);
        case (mode)
            LFSR_FIB: begin
                res    = state << 1;
                res[0] = fb;
            end
            LFSR_GAL: begin
                res    = (state << 1) ^ (taps & {LFSR_MAX_W{msb}});
                res[0] = msb;
            end
            default: begin
                res = state;
            end
        endcase
        return res & mask;
    endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Control/status bundle between an LFSR generator and its user.
interface lfsr_gen_if import lfsr_pkg::*; #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 16
);
    logic             reinit;
    logic             advance;
    lfsr_mode_e       mode;
    logic [WIDTH-1:0] initial_state;
    logic [WIDTH-1:0] taps;
    logic             out;
    logic [WIDTH-1:0] out_state;
    logic             lockup;
    logic             period_hit;
    logic [CNT_W-1:0] period_len;

    modport master (
        output reinit, advance, mode, initial_state, taps,
        input  out, out_state, lockup, period_hit, period_len
    );

    modport slave (
        input  reinit, advance, mode, initial_state, taps,
        output out, out_state, lockup, period_hit, period_len
    );
endinterface

// File: rtl/lfsr_next.sv
// Combinational next-state: STEP chained single shifts of the LFSR in the selected mode.
module lfsr_next import lfsr_pkg::*; #(
    parameter int WIDTH = 5,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    input  lfsr_mode_e       mode,
    output logic [WIDTH-1:0] next_state
);
    lfsr_word_t work_s;

    // Unroll the STEP shifts; each stage feeds the next within one cycle.
    always_comb begin
        work_s = lfsr_word_t'(state);
        for (int k = 0; k < STEP; k++) begin
            work_s = lfsr_shift1(work_s, lfsr_word_t'(taps), mode, WIDTH);
        end
    end

    assign next_state = work_s[WIDTH-1:0];
endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator with runtime taps/seed/mode, lock-up recovery and period measurement.
module lfsr_gen import lfsr_pkg::*; #(
    parameter int WIDTH        = 5,
    parameter int STEP         = 1,
    parameter int CNT_W        = 16,
    parameter int AUTO_RECOVER = 1
) (
    input logic       clk,
    input logic       rst,
    lfsr_gen_if.slave bus
);
    localparam logic RECOVER_EN = (AUTO_RECOVER != 0);

    logic [WIDTH-1:0] state_r;
    logic [WIDTH-1:0] seed_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] len_r;
    logic             hit_r;
    logic             lockup_r;

    logic [WIDTH-1:0] shift_s;
    logic [WIDTH-1:0] recover_s;
    logic [WIDTH-1:0] state_nxt_s;
    logic [WIDTH-1:0] seed_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] len_nxt_s;
    logic             hit_nxt_s;

    lfsr_next #(.WIDTH(WIDTH), .STEP(STEP)) u_next (
        .state      (state_r),
        .taps       (bus.taps),
        .mode       (bus.mode),
        .next_state (shift_s)
    );

    assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    assign recover_s = (bus.initial_state != {WIDTH{1'b0}}) ? bus.initial_state
                                                            : {{(WIDTH-1){1'b0}}, 1'b1};

    // Next-state selection: reinit over advance over hold.
    always_comb begin
        state_nxt_s = state_r;
        seed_nxt_s  = seed_r;
        cnt_nxt_s   = cnt_r;
        len_nxt_s   = len_r;
        hit_nxt_s   = 1'b0;
        if (bus.reinit) begin
            state_nxt_s = bus.initial_state;
            seed_nxt_s  = bus.initial_state;
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (bus.advance) begin
            if (RECOVER_EN && (state_r == {WIDTH{1'b0}})) begin
                // Recovery acts as a fresh load, so the period restarts from the reloaded value.
                state_nxt_s = recover_s;
                seed_nxt_s  = recover_s;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end else if (shift_s == seed_r) begin
                state_nxt_s = shift_s;
                hit_nxt_s   = 1'b1;
                len_nxt_s   = cnt_inc_s;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end else begin
                state_nxt_s = shift_s;
                cnt_nxt_s   = cnt_inc_s;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, seed and period registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= bus.initial_state;
            seed_r   <= bus.initial_state;
            cnt_r    <= {CNT_W{1'b0}};
            len_r    <= {CNT_W{1'b0}};
            hit_r    <= 1'b0;
            lockup_r <= (bus.initial_state == {WIDTH{1'b0}});
        end else begin
            state_r  <= state_nxt_s;
            seed_r   <= seed_nxt_s;
            cnt_r    <= cnt_nxt_s;
            len_r    <= len_nxt_s;
            hit_r    <= hit_nxt_s;
            lockup_r <= (state_nxt_s == {WIDTH{1'b0}});
        end
    end

    assign bus.out        = state_r[0];
    assign bus.out_state  = state_r;
    assign bus.lockup     = lockup_r;
    assign bus.period_hit = hit_r;
    assign bus.period_len = len_r;
endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench: default build, a STEP=2 build and an AUTO_RECOVER=0 build share one stimulus.
module tb_lfsr_gen;
    import lfsr_pkg::*;

    logic       clk;
    logic       rst;
    logic       reinit;
    logic       advance;
    lfsr_mode_e mode;
    logic [4:0] init;
    logic [4:0] taps;

    int checks;
    int errors;

    lfsr_gen_if #(.WIDTH(5), .CNT_W(16)) if_a ();
    lfsr_gen_if #(.WIDTH(5), .CNT_W(16)) if_b ();
    lfsr_gen_if #(.WIDTH(5), .CNT_W(16)) if_c ();

    assign if_a.reinit = reinit;  assign if_b.reinit = reinit;  assign if_c.reinit = reinit;
    assign if_a.advance = advance; assign if_b.advance = advance; assign if_c.advance = advance;
    assign if_a.mode = mode;      assign if_b.mode = mode;      assign if_c.mode = mode;
    assign if_a.initial_state = init; assign if_b.initial_state = init; assign if_c.initial_state = init;
    assign if_a.taps = taps;      assign if_b.taps = taps;      assign if_c.taps = taps;

    lfsr_gen #(.WIDTH(5), .STEP(1), .CNT_W(16), .AUTO_RECOVER(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    lfsr_gen #(.WIDTH(5), .STEP(2), .CNT_W(16), .AUTO_RECOVER(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    lfsr_gen #(.WIDTH(5), .STEP(1), .CNT_W(16), .AUTO_RECOVER(0)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        init = 5'b00001; rst = 1'b1; reinit = 1'b0; advance = 1'b0;
        mode = LFSR_FIB; taps = 5'b10100;
        step();
        rst = 1'b0;
        checks++; if (if_a.out_state !== 5'b00001) begin errors++; $display("FAIL reset_state got %b exp 00001", if_a.out_state); end
        checks++; if (if_a.out !== 1'b1) begin errors++; $display("FAIL reset_out got %b exp 1", if_a.out); end
        checks++; if (if_a.lockup !== 1'b0) begin errors++; $display("FAIL reset_lockup got %b exp 0", if_a.lockup); end
        checks++; if (if_a.period_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", if_a.period_hit); end
        checks++; if (if_a.period_len !== 16'd0) begin errors++; $display("FAIL reset_len got %0d exp 0", if_a.period_len); end
    endtask

    task automatic test_fib_short();
        logic [4:0] exp_s [3];
        exp_s[0] = 5'b00010; exp_s[1] = 5'b00100; exp_s[2] = 5'b01001;
        advance = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (if_a.out_state !== exp_s[i]) begin errors++; $display("FAIL fib_state[%0d] got %b exp %b", i, if_a.out_state, exp_s[i]); end
            checks++; if (if_a.out !== exp_s[i][0]) begin errors++; $display("FAIL fib_out[%0d] got %b exp %b", i, if_a.out, exp_s[i][0]); end
        end
        advance = 1'b0;
    endtask

    task automatic test_fib_period();
        int hits;
        hits = 0;
        init = 5'b00001; reinit = 1'b1;
        step();
        reinit = 1'b0;
        checks++; if (if_a.period_hit !== 1'b0) begin errors++; $display("FAIL load_no_hit got %b exp 0", if_a.period_hit); end
        advance = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            step();
            if (if_a.period_hit === 1'b1) hits++;
        end
        advance = 1'b0;
        checks++; if (if_a.period_hit !== 1'b1) begin errors++; $display("FAIL period_hit got %b exp 1", if_a.period_hit); end
        checks++; if (hits !== 1) begin errors++; $display("FAIL period_hit_count got %0d exp 1", hits); end
        checks++; if (if_a.period_len !== 16'd31) begin errors++; $display("FAIL period_len got %0d exp 31", if_a.period_len); end
        checks++; if (if_a.out_state !== 5'b00001) begin errors++; $display("FAIL period_state got %b exp 00001", if_a.out_state); end
        step();
        checks++; if (if_a.period_hit !== 1'b0) begin errors++; $display("FAIL hit_pulse_width got %b exp 0", if_a.period_hit); end
    endtask

    task automatic test_galois();
        mode = LFSR_GAL; taps = 5'b00101; init = 5'b10000; reinit = 1'b1;
        step();
        reinit = 1'b0; advance = 1'b1;
        step();
        advance = 1'b0;
        checks++; if (if_a.out_state !== 5'b00101) begin errors++; $display("FAIL gal_step1 got %b exp 00101", if_a.out_state); end
        checks++; if (if_a.out !== 1'b1) begin errors++; $display("FAIL gal_out got %b exp 1", if_a.out); end
        checks++; if (if_b.out_state !== 5'b01010) begin errors++; $display("FAIL gal_step2 got %b exp 01010", if_b.out_state); end
    endtask

    task automatic test_lockup();
        mode = LFSR_FIB; taps = 5'b10100; init = 5'b00000; reinit = 1'b1;
        step();
        reinit = 1'b0;
        checks++; if (if_a.lockup !== 1'b1) begin errors++; $display("FAIL lock_flag got %b exp 1", if_a.lockup); end
        checks++; if (if_a.out_state !== 5'b00000) begin errors++; $display("FAIL lock_state got %b exp 00000", if_a.out_state); end
        advance = 1'b1;
        step();
        advance = 1'b0;
        checks++; if (if_a.out_state !== 5'b00001) begin errors++; $display("FAIL recover_state got %b exp 00001", if_a.out_state); end
        checks++; if (if_a.lockup !== 1'b0) begin errors++; $display("FAIL recover_lockup got %b exp 0", if_a.lockup); end
        checks++; if (if_c.out_state !== 5'b00000) begin errors++; $display("FAIL norecover_state got %b exp 00000", if_c.out_state); end
        checks++; if (if_c.lockup !== 1'b1) begin errors++; $display("FAIL norecover_lockup got %b exp 1", if_c.lockup); end
    endtask

    task automatic test_reinit_mid();
        int hits;
        hits = 0;
        mode = LFSR_FIB; taps = 5'b10100; init = 5'b00001; reinit = 1'b1;
        step();
        reinit = 1'b0; advance = 1'b1;
        for (int i = 0; i < 5; i++) step();
        init = 5'b00110; reinit = 1'b1;
        step();
        reinit = 1'b0;
        checks++; if (if_a.out_state !== 5'b00110) begin errors++; $display("FAIL reinit_adv_state got %b exp 00110", if_a.out_state); end
        checks++; if (if_a.period_hit !== 1'b0) begin errors++; $display("FAIL reinit_adv_hit got %b exp 0", if_a.period_hit); end
        for (int i = 1; i <= 31; i++) begin
            step();
            if (if_a.period_hit === 1'b1) hits++;
        end
        checks++; if (if_a.period_hit !== 1'b1 || hits !== 1) begin errors++; $display("FAIL reinit_period_hit got %b/%0d exp 1/1", if_a.period_hit, hits); end
        checks++; if (if_a.period_len !== 16'd31) begin errors++; $display("FAIL reinit_period_len got %0d exp 31", if_a.period_len); end
        checks++; if (if_a.out_state !== 5'b00110) begin errors++; $display("FAIL reinit_period_state got %b exp 00110", if_a.out_state); end
        for (int i = 0; i < 3; i++) step();
        advance = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (if_a.period_len !== 16'd0) begin errors++; $display("FAIL rst_len got %0d exp 0", if_a.period_len); end
        checks++; if (if_a.out_state !== 5'b00110) begin errors++; $display("FAIL rst_state got %b exp 00110", if_a.out_state); end
        checks++; if (if_a.period_hit !== 1'b0) begin errors++; $display("FAIL rst_hit got %b exp 0", if_a.period_hit); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fib_short();
        test_fib_period();
        test_galois();
        test_lockup();
        test_reinit_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
